// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O block: register offsets,
// CTRL bit positions and the default window base.
package io_pkg;

  typedef enum logic [2:0] {
    IO_LED    = 3'd0,
    IO_BTN    = 3'd1,
    IO_EDGE   = 3'd2,
    IO_COUNT  = 3'd3,
    IO_RELOAD = 3'd4,
    IO_CTRL   = 3'd5,
    IO_STATUS = 3'd6,
    IO_RSVD   = 3'd7
  } io_reg_e;

  localparam int CTRL_TEN = 0;  // timer enable
  localparam int CTRL_TIE = 1;  // timer interrupt enable
  localparam int CTRL_BIE = 2;  // button interrupt enable

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFC00;

  // Place the addressed byte lane of a register word onto the read bus.
  function automatic logic [15:0] lane_rd(input logic [15:0] word,
                                          input logic        wide,
                                          input logic        hi);
    if (wide)
      return word;
    else if (hi)
      return {8'h00, word[15:8]};
    else
      return {8'h00, word[7:0]};
  endfunction

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-FF synchroniser, periodic sample strobe, and a
// debounced level that only follows the input after two agreeing samples.
// rise pulses in the strobe cycle in which a level bit is about to go 0->1.
module debounce #(
  parameter int WIDTH    = 7,
  parameter int DEBOUNCE = 250000
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  localparam int            CW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] agree;
  logic [CW-1:0]    cnt;
  logic             strobe;

  assign strobe = (cnt == LAST);
  assign agree  = ~(sync_p1 ^ prev);
  assign rise   = {WIDTH{strobe}} & agree & sync_p1 & ~level;

  // Two-stage synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Free-running sample interval counter; strobe on its last count.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      cnt <= '0;
    else if (strobe)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // On each strobe, adopt the sample only where it matches the previous one.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      prev  <= '0;
      level <= '0;
    end else if (strobe) begin
      prev  <= sync_p1;
      level <= (level & ~agree) | (sync_p1 & agree);
    end
  end

endmodule

// File: rtl/io_ctl.sv
// Memory-mapped I/O responder: LED latch, debounced buttons with press
// capture, reloadable interval timer and a combined level interrupt.
// Reads return one cycle after the access, zero otherwise, so the data can
// be ORed with the block RAM output.
module io_ctl
  import io_pkg::*;
#(
  parameter logic [15:0] BASE     = IO_BASE_DEFAULT,
  parameter int          DEBOUNCE = 250000,
  parameter int          PRESCALE = 25
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        en,
  input  logic        wr,
  input  logic        wide,
  input  logic [15:0] addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        sel,
  input  logic [6:0]  btn,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  // bus decode
  logic        hit;
  logic        hi;
  io_reg_e     off;
  logic [1:0]  be;
  logic [15:0] wdat;
  logic        wr_led, wr_edge, wr_reload, wr_ctrl, wr_status;

  // register state
  logic [2:0]  ctrl;
  logic [15:0] reload;
  logic [15:0] count;
  logic [PW-1:0] pcnt;
  logic        status;
  logic [6:0]  btn_edge;
  logic [6:0]  btn_lvl;
  logic [6:0]  btn_rise;
  logic        tick;
  logic        start;
  logic [15:0] rd_word;

  assign sel  = (addr[15:4] == BASE[15:4]);
  assign hit  = en & sel;
  assign hi   = addr[0] & ~wide;
  assign off  = io_reg_e'(addr[3:1]);
  assign be   = wide ? 2'b11 : (hi ? 2'b10 : 2'b01);
  assign wdat = wide ? din : {din[7:0], din[7:0]};

  assign wr_led    = hit & wr & (off == IO_LED);
  assign wr_edge   = hit & wr & (off == IO_EDGE);
  assign wr_reload = hit & wr & (off == IO_RELOAD);
  assign wr_ctrl   = hit & wr & (off == IO_CTRL);
  assign wr_status = hit & wr & (off == IO_STATUS);

  assign tick  = ctrl[CTRL_TEN] & (pcnt == PLAST);
  // Only a 0->1 transition of the enable restarts the count.
  assign start = wr_ctrl & be[0] & wdat[CTRL_TEN] & ~ctrl[CTRL_TEN];

  debounce #(
    .WIDTH   (7),
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .nreset(nreset),
    .raw   (btn),
    .level (btn_lvl),
    .rise  (btn_rise)
  );

  // Software-writable registers: LED, RELOAD, CTRL (byte-lane merged).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      led    <= '0;
      reload <= '0;
      ctrl   <= '0;
    end else begin
      if (wr_led && be[0])
        led <= wdat[7:0];
      if (wr_reload)
        reload <= {be[1] ? wdat[15:8] : reload[15:8],
                   be[0] ? wdat[7:0]  : reload[7:0]};
      if (wr_ctrl && be[0])
        ctrl <= wdat[2:0];
    end
  end

  // Prescaler and down-counter; holds while disabled, reloads on underflow.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pcnt  <= '0;
      count <= '0;
    end else if (start) begin
      pcnt  <= '0;
      count <= reload;
    end else if (ctrl[CTRL_TEN]) begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick)
        count <= (count == 16'd0) ? reload : count - 16'd1;
    end
  end

  // Sticky event bits; a hardware set beats a same-cycle W1C clear.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      status   <= 1'b0;
      btn_edge <= '0;
    end else begin
      status   <= (status & ~(wr_status & be[0] & wdat[0]))
                | (tick & (count == 16'd0));
      btn_edge <= (btn_edge & ~({7{wr_edge & be[0]}} & wdat[6:0])) | btn_rise;
    end
  end

  // Word-level read mux for the addressed register.
  always_comb begin
    rd_word = '0;
    case (off)
      IO_LED:    rd_word = {8'h00, led};
      IO_BTN:    rd_word = {9'h000, btn_lvl};
      IO_EDGE:   rd_word = {9'h000, btn_edge};
      IO_COUNT:  rd_word = count;
      IO_RELOAD: rd_word = reload;
      IO_CTRL:   rd_word = {13'h0000, ctrl};
      IO_STATUS: rd_word = {15'h0000, status};
      default:   rd_word = '0;
    endcase
  end

  // Registered read data (zero when not a hit read) and interrupt level.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      dout <= '0;
      irq  <= 1'b0;
    end else begin
      dout <= (hit && !wr) ? lane_rd(rd_word, wide, hi) : 16'h0000;
      irq  <= (status & ctrl[CTRL_TIE]) | ((|btn_edge) & ctrl[CTRL_BIE]);
    end
  end

endmodule
